// File: rtl/gpi_debounce_if.sv
// Signal bundle between board-pin conditioner and GPI peripheral.
// No latency of its own; pure wiring.
// No backpressure; en is the only control. Edge-latch signals exist only with GPI_DEBOUNCE_EDGE_LATCH_EN.
interface gpi_debounce_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [WIDTH-1:0] in_raw;
    logic [WIDTH-1:0] out_stable;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;
`ifdef GPI_DEBOUNCE_EDGE_LATCH_EN
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] edge_flags;
    logic             irq;

    // Driver side: pins, enable and flag clears in; conditioned levels and events out.
    modport master (
        output en, in_raw, clr,
        input  out_stable, rise_pulse, fall_pulse, edge_flags, irq
    );

    // Debouncer side.
    modport slave (
        input  en, in_raw, clr,
        output out_stable, rise_pulse, fall_pulse, edge_flags, irq
    );
`else
    // Driver side: pins and enable in; conditioned levels and events out.
    modport master (
        output en, in_raw,
        input  out_stable, rise_pulse, fall_pulse
    );

    // Debouncer side.
    modport slave (
        input  en, in_raw,
        output out_stable, rise_pulse, fall_pulse
    );
`endif
endinterface

// File: rtl/gpi_debounce.sv
// Per-bit 2-flop synchroniser + stability counter producing clean levels and rise/fall pulses.
// Latency: DEBOUNCE_CYCLES+2 rising edges from a clean pin change to out_stable.
// No backpressure; en=0 freezes accepted levels. GPI_DEBOUNCE_EDGE_LATCH_EN adds sticky edge flags + irq.
module gpi_debounce #(
    parameter int WIDTH           = 8,
    parameter int CNT_W           = 20,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic          clk,
    input  logic          rst,
    gpi_debounce_if.slave bus
);

    localparam longint CNT_LIMIT = (longint'(1) << CNT_W) - 1;

    // A zero or over-range debounce length cannot be represented by the counter.
    generate
        if (DEBOUNCE_CYCLES < 1 || longint'(DEBOUNCE_CYCLES) > CNT_LIMIT) begin : g_bad_cfg
            $error("gpi_debounce: DEBOUNCE_CYCLES out of range for CNT_W");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // Synchroniser chain runs regardless of en so the level is settled when counting resumes.
    always_comb begin
        sync1_d = bus.in_raw;
        sync2_d = sync1_q;
    end

    // Stability counter: a mismatch must persist DEBOUNCE_CYCLES edges; any agreement restarts it.
    always_comb begin
        stable_d = stable_q;
        rise_d   = '0;
        fall_d   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (bus.en && (sync2_q[i] != stable_q[i])) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync2_q[i];
                    rise_d[i]   = sync2_q[i];
                    fall_d[i]   = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Core state registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.out_stable = stable_q;
    assign bus.rise_pulse = rise_q;
    assign bus.fall_pulse = fall_q;

`ifdef GPI_DEBOUNCE_EDGE_LATCH_EN
    logic [WIDTH-1:0] flags_q, flags_d;

    // Sticky edge record; a new edge beats a simultaneous clear.
    always_comb begin
        flags_d = (flags_q & ~bus.clr) | rise_q | fall_q;
    end

    // Edge flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign bus.edge_flags = flags_q;
    assign bus.irq        = |flags_q;
`endif

endmodule

// File: tb/tb_gpi_debounce.sv
// Scoreboard bench for gpi_debounce with WIDTH=8, CNT_W=4, DEBOUNCE_CYCLES=4.
// Expectations are queued with the edge count at which they must hold.
// Outputs are sampled on the falling edge.
module tb_gpi_debounce;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   edges = 0;
    int   n_chk = 0;
    int   n_err = 0;

    typedef struct {
        string      tag;
        int         due;
        bit         core;
        logic [7:0] out;
        logic [7:0] rise;
        logic [7:0] fall;
        bit         flg;
        logic [7:0] flags;
        logic       irq;
    } exp_t;

    exp_t sb[$];

    gpi_debounce_if #(.WIDTH(W)) bus ();

    gpi_debounce #(
        .WIDTH          (W),
        .CNT_W          (4),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edges);
        end
    endtask

    task automatic exp_core(input string tag, input int due,
                            input logic [7:0] o, input logic [7:0] r, input logic [7:0] f);
        exp_t e;
        e.tag = tag; e.due = due; e.core = 1'b1;
        e.out = o; e.rise = r; e.fall = f;
        e.flg = 1'b0; e.flags = '0; e.irq = 1'b0;
        sb.push_back(e);
    endtask

    task automatic exp_win(input string tag, input int from, input int to,
                           input logic [7:0] o, input logic [7:0] r, input logic [7:0] f);
        for (int c = from; c <= to; c++) exp_core(tag, c, o, r, f);
    endtask

    task automatic exp_flag(input string tag, input int due, input logic [7:0] fl, input logic iq);
        exp_t e;
        e.tag = tag; e.due = due; e.core = 1'b0;
        e.out = '0; e.rise = '0; e.fall = '0;
        e.flg = 1'b1; e.flags = fl; e.irq = iq;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clean change: settles DEBOUNCE_CYCLES+2 = 6 edges after the drive.
    task automatic drive_change(input string tag, input logic [7:0] old_v, input logic [7:0] new_v);
        int e;
        e = edges;
        bus.in_raw = new_v;
        exp_win({tag, "_wait"}, e + 1, e + 5, old_v, 8'h00, 8'h00);
        exp_core({tag, "_acc"}, e + 6, new_v, new_v & ~old_v, old_v & ~new_v);
        exp_win({tag, "_hold"}, e + 7, e + 9, new_v, 8'h00, 8'h00);
        step(10);
    endtask

    // Scoreboard consumer: compares every entry whose due edge count is now.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == edges) begin
                    if (sb[i].core) begin
                        chk({sb[i].tag, "_out"},  {24'h0, bus.out_stable}, {24'h0, sb[i].out});
                        chk({sb[i].tag, "_rise"}, {24'h0, bus.rise_pulse}, {24'h0, sb[i].rise});
                        chk({sb[i].tag, "_fall"}, {24'h0, bus.fall_pulse}, {24'h0, sb[i].fall});
                    end
`ifdef GPI_DEBOUNCE_EDGE_LATCH_EN
                    if (sb[i].flg) begin
                        chk({sb[i].tag, "_flags"}, {24'h0, bus.edge_flags}, {24'h0, sb[i].flags});
                        chk({sb[i].tag, "_irq"},   {31'h0, bus.irq},        {31'h0, sb[i].irq});
                    end
`endif
                    sb.delete(i);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        logic [7:0] bounce [6];
        bounce[0] = 8'h08; bounce[1] = 8'h00; bounce[2] = 8'h08;
        bounce[3] = 8'h08; bounce[4] = 8'h00; bounce[5] = 8'h08;

        bus.en     = 1'b1;
        bus.in_raw = 8'h00;
`ifdef GPI_DEBOUNCE_EDGE_LATCH_EN
        bus.clr    = 8'h00;
`endif
        step(2);
        chk("reset_out",  {24'h0, bus.out_stable}, 32'h0);
        chk("reset_rise", {24'h0, bus.rise_pulse}, 32'h0);
        chk("reset_fall", {24'h0, bus.fall_pulse}, 32'h0);
        rst = 1'b0;

        // Idle input stays quiet.
        exp_win("t1_idle", edges + 1, edges + 20, 8'h00, 8'h00, 8'h00);
        step(20);

        // Accept all ones, then reset asynchronously between edges.
        e = edges;
        bus.in_raw = 8'hFF;
        exp_win("t1_pre", e + 1, e + 5, 8'h00, 8'h00, 8'h00);
        exp_core("t1_acc", e + 6, 8'hFF, 8'hFF, 8'h00);
        step(7);
        #2;
        rst = 1'b1;
        #1;
        chk("t1_arst_out",  {24'h0, bus.out_stable}, 32'h0);
        chk("t1_arst_rise", {24'h0, bus.rise_pulse}, 32'h0);
        chk("t1_arst_fall", {24'h0, bus.fall_pulse}, 32'h0);
        @(negedge clk);
        bus.in_raw = 8'h00;
        step(3);
        rst = 1'b0;
        exp_win("t1_post", edges + 1, edges + 5, 8'h00, 8'h00, 8'h00);
        step(5);

        // Single-bit clean rise and fall.
        drive_change("t2_rise", 8'h00, 8'h01);
        drive_change("t2_fall", 8'h01, 8'h00);

        // Bounce on bit 3, then a held 1.
        e = edges;
        exp_win("t3_bounce", e + 1, e + 10, 8'h00, 8'h00, 8'h00);
        exp_core("t3_acc", e + 11, 8'h08, 8'h08, 8'h00);
        exp_win("t3_hold", e + 12, e + 14, 8'h08, 8'h00, 8'h00);
        for (int i = 0; i < 6; i++) begin
            bus.in_raw = bounce[i];
            if (i < 5) step(1);
        end
        step(10);
        drive_change("t3_rel", 8'h08, 8'h00);

        // Disabled: nothing accepted; enabling accepts after 4 edges.
        e = edges;
        bus.en = 1'b0;
        bus.in_raw = 8'hA5;
        exp_win("t4_frozen", e + 1, e + 10, 8'h00, 8'h00, 8'h00);
        step(10);
        e = edges;
        bus.en = 1'b1;
        exp_win("t4_count", e + 1, e + 3, 8'h00, 8'h00, 8'h00);
        exp_core("t4_acc", e + 4, 8'hA5, 8'hA5, 8'h00);
        exp_win("t4_hold", e + 5, e + 7, 8'hA5, 8'h00, 8'h00);
        step(8);
        drive_change("t4_rel", 8'hA5, 8'h00);

        // All bits at once.
        drive_change("t5_all", 8'h00, 8'hFF);
        drive_change("t5_rel", 8'hFF, 8'h00);

`ifdef GPI_DEBOUNCE_EDGE_LATCH_EN
        // Edge latch: set after pulse, clear, and set-wins-over-clear.
        e = edges;
        exp_flag("t6_pre", e + 6, 8'h00, 1'b0);
        exp_flag("t6_set", e + 7, 8'h04, 1'b1);
        exp_flag("t6_sticky", e + 9, 8'h04, 1'b1);
        drive_change("t6_rise", 8'h00, 8'h04);
        bus.clr = 8'h04;
        exp_flag("t6_clr", edges + 1, 8'h00, 1'b0);
        step(1);
        bus.clr = 8'h00;
        exp_flag("t6_clr_hold", edges + 1, 8'h00, 1'b0);
        step(2);
        e = edges;
        bus.in_raw = 8'h00;
        exp_core("t6_fall", e + 6, 8'h00, 8'h00, 8'h04);
        exp_flag("t6_fall_pre", e + 6, 8'h00, 1'b0);
        step(6);
        bus.clr = 8'h04;
        exp_flag("t6_setwins", edges + 1, 8'h04, 1'b1);
        step(1);
        bus.clr = 8'h00;
        exp_flag("t6_setwins_hold", edges + 1, 8'h04, 1'b1);
        step(3);
        bus.clr = 8'hFB;
        exp_flag("t6_clr_other", edges + 1, 8'h04, 1'b1);
        step(1);
        bus.clr = 8'h00;
        step(2);
`endif

        // Drain: every queued expectation must have been consumed.
        for (int i = 0; i < 50 && sb.size() > 0; i++) step(1);
        chk("sb_drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
